disc_motion_engine: RTL and testbench



---
 rtl/disc_motion_pkg.sv | 33 +++
 rtl/disc_motion_engine_axis_step.sv | 38 +++
 rtl/disc_motion_engine.sv | 122 ++++++++++++
 tb/tb_disc_motion_engine.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disc_motion_pkg.sv
// Shared types, default geometry and the constant start-up tables
// for the disc motion engine.
package disc_motion_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    PUBLISH
  } state_t;

  localparam int MAX_DISCS   = 8;
  localparam int DEF_N_DISCS = 4;
  localparam int DEF_H_RES   = 640;
  localparam int DEF_V_RES   = 480;
  localparam int DEF_RADIUS  = 32;
  localparam int DEF_COORD_W = 10;
  localparam int DEF_VEL_W   = 4;

  localparam int DEF_LO   = DEF_RADIUS;
  localparam int DEF_HI_X = DEF_H_RES - 1 - DEF_RADIUS;
  localparam int DEF_HI_Y = DEF_V_RES - 1 - DEF_RADIUS;

  // Disc 1 starts next to the right/bottom walls so it bounces at once.
  localparam int INIT_X [MAX_DISCS] =
    '{100, 605, 320, 480, 200, 400, 150, 500};
  localparam int INIT_Y [MAX_DISCS] =
    '{100, 446, 240, 300, 350, 120, 400, 200};
  localparam int INIT_VX [MAX_DISCS] =
    '{3, 4, -5, 7, -2, 6, -7, 1};
  localparam int INIT_VY [MAX_DISCS] =
    '{-2, 3, 6, -4, 5, -7, 2, -3};

endpackage

// File: rtl/disc_motion_engine_axis_step.sv
// One-axis position/velocity update with reflection at the lo/hi
// limits; evaluated in a widened signed space to catch both overflows.
module disc_axis_step #(
  parameter int COORD_W = 10,
  parameter int VEL_W   = 4
) (
  input  logic [COORD_W-1:0]      p,
  input  logic signed [VEL_W-1:0] v,
  input  logic [COORD_W-1:0]      lo,
  input  logic [COORD_W-1:0]      hi,
  output logic [COORD_W-1:0]      p_nxt,
  output logic signed [VEL_W-1:0] v_nxt
);

  localparam int SW = COORD_W + 2;

  logic signed [SW-1:0] n;
  logic signed [SW-1:0] v_s;
  logic signed [SW-1:0] lo_s;
  logic signed [SW-1:0] hi_s;

  always_comb begin
    v_s   = {{(SW-VEL_W){v[VEL_W-1]}}, v};
    n     = $signed({2'b00, p}) + v_s;
    lo_s  = $signed({2'b00, lo});
    hi_s  = $signed({2'b00, hi});
    p_nxt = n[COORD_W-1:0];
    v_nxt = v;
    if (n < lo_s) begin
      p_nxt = lo;
      v_nxt = -v;
    end else if (n > hi_s) begin
      p_nxt = hi;
      v_nxt = -v;
    end
  end

endmodule

// File: rtl/disc_motion_engine.sv
// Frame-synchronous disc motion: one disc stepped per clock after each
// vsync falling edge, then the whole set published in a single cycle.
module disc_motion_engine
  import disc_motion_pkg::*;
#(
  parameter int N_DISCS = DEF_N_DISCS,
  parameter int H_RES   = DEF_H_RES,
  parameter int V_RES   = DEF_V_RES,
  parameter int RADIUS  = DEF_RADIUS,
  parameter int COORD_W = DEF_COORD_W,
  parameter int VEL_W   = DEF_VEL_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       vsync,
  input  logic                       enable,
  output logic [N_DISCS*COORD_W-1:0] disc_x,
  output logic [N_DISCS*COORD_W-1:0] disc_y,
  output logic                       busy,
  output logic                       update_done,
  output logic                       overrun
);

  localparam int IDX_W = (N_DISCS > 1) ? $clog2(N_DISCS) : 1;

  localparam logic [COORD_W-1:0] LO   = COORD_W'(RADIUS);
  localparam logic [COORD_W-1:0] HI_X = COORD_W'(H_RES - 1 - RADIUS);
  localparam logic [COORD_W-1:0] HI_Y = COORD_W'(V_RES - 1 - RADIUS);
  localparam logic [IDX_W-1:0]   LAST = IDX_W'(N_DISCS - 1);

  state_t state;
  state_t state_nxt;

  logic [IDX_W-1:0] idx;
  logic             vs_d;
  logic             frame_edge;

  logic [COORD_W-1:0]      wx  [N_DISCS];
  logic [COORD_W-1:0]      wy  [N_DISCS];
  logic signed [VEL_W-1:0] wvx [N_DISCS];
  logic signed [VEL_W-1:0] wvy [N_DISCS];

  logic [COORD_W-1:0]      nx;
  logic [COORD_W-1:0]      ny;
  logic signed [VEL_W-1:0] nvx;
  logic signed [VEL_W-1:0] nvy;

  assign frame_edge = vs_d & ~vsync;
  assign busy       = (state != IDLE);

  disc_axis_step #(
    .COORD_W(COORD_W),
    .VEL_W  (VEL_W)
  ) u_step_x (
    .p    (wx[idx]),
    .v    (wvx[idx]),
    .lo   (LO),
    .hi   (HI_X),
    .p_nxt(nx),
    .v_nxt(nvx)
  );

  disc_axis_step #(
    .COORD_W(COORD_W),
    .VEL_W  (VEL_W)
  ) u_step_y (
    .p    (wy[idx]),
    .v    (wvy[idx]),
    .lo   (LO),
    .hi   (HI_Y),
    .p_nxt(ny),
    .v_nxt(nvy)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (frame_edge && enable) state_nxt = STEP;
      STEP:    if (idx == LAST) state_nxt = PUBLISH;
      PUBLISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      vs_d        <= 1'b1;
      update_done <= 1'b0;
      overrun     <= 1'b0;
      for (int i = 0; i < N_DISCS; i++) begin
        wx[i]  <= COORD_W'(INIT_X[i]);
        wy[i]  <= COORD_W'(INIT_Y[i]);
        wvx[i] <= VEL_W'(INIT_VX[i]);
        wvy[i] <= VEL_W'(INIT_VY[i]);
        disc_x[i*COORD_W +: COORD_W] <= COORD_W'(INIT_X[i]);
        disc_y[i*COORD_W +: COORD_W] <= COORD_W'(INIT_Y[i]);
      end
    end else begin
      state       <= state_nxt;
      vs_d        <= vsync;
      update_done <= (state == PUBLISH);
      if (frame_edge && busy) overrun <= 1'b1;
      if (state == IDLE) idx <= '0;
      if (state == STEP) begin
        wx[idx]  <= nx;
        wy[idx]  <= ny;
        wvx[idx] <= nvx;
        wvy[idx] <= nvy;
        if (idx != LAST) idx <= idx + 1'b1;
      end
      if (state == PUBLISH) begin
        for (int i = 0; i < N_DISCS; i++) begin
          disc_x[i*COORD_W +: COORD_W] <= wx[i];
          disc_y[i*COORD_W +: COORD_W] <= wy[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_disc_motion_engine.sv
// Randomized frame-level checks of disc_motion_engine against an
// integer reference model of bouncing discs.
module tb_disc_motion_engine;

  localparam int N    = 4;
  localparam int CW   = 10;
  localparam int LO   = 32;
  localparam int HI_X = 607;
  localparam int HI_Y = 447;

  localparam int TX  [N] = '{100, 605, 320, 480};
  localparam int TY  [N] = '{100, 446, 240, 300};
  localparam int TVX [N] = '{3, 4, -5, 7};
  localparam int TVY [N] = '{-2, 3, 6, -4};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vsync = 1'b1;
  logic enable = 1'b0;
  logic [N*CW-1:0] disc_x;
  logic [N*CW-1:0] disc_y;
  logic busy;
  logic update_done;
  logic overrun;

  int tests = 0;
  int fails = 0;
  int mx [N];
  int my [N];
  int mvx [N];
  int mvy [N];
  logic exp_ovr;

  always #5 clk = ~clk;

  disc_motion_engine dut (
    .clk        (clk),
    .rst        (rst),
    .vsync      (vsync),
    .enable     (enable),
    .disc_x     (disc_x),
    .disc_y     (disc_y),
    .busy       (busy),
    .update_done(update_done),
    .overrun    (overrun)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic void axis(input int p, input int v, input int hi,
                               output int pn, output int vn);
    int n;
    n  = p + v;
    pn = n;
    vn = v;
    if (n < LO) begin
      pn = LO;
      vn = -v;
    end else if (n > hi) begin
      pn = hi;
      vn = -v;
    end
  endfunction

  function automatic void model_reset;
    for (int i = 0; i < N; i++) begin
      mx[i]  = TX[i];
      my[i]  = TY[i];
      mvx[i] = TVX[i];
      mvy[i] = TVY[i];
    end
  endfunction

  function automatic void model_frame;
    int p, v;
    for (int i = 0; i < N; i++) begin
      axis(mx[i], mvx[i], HI_X, p, v);
      mx[i] = p;
      mvx[i] = v;
      axis(my[i], mvy[i], HI_Y, p, v);
      my[i] = p;
      mvy[i] = v;
    end
  endfunction

  function automatic logic [N*CW-1:0] pack(input bit ysel);
    logic [N*CW-1:0] r;
    for (int i = 0; i < N; i++)
      r[i*CW +: CW] = CW'(ysel ? my[i] : mx[i]);
    return r;
  endfunction

  task automatic do_reset;
    rst = 1'b1;
    vsync = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    exp_ovr = 1'b0;
  endtask

  // One vsync edge at cycle 0; every following cycle is checked.
  task automatic do_frame(input logic en, input logic drop,
                          input logic second_edge, input string tag);
    logic eb, ed;
    enable = en;
    vsync = 1'b0;
    for (int k = 1; k <= N + 4; k++) begin
      tick();
      if (en && k == N + 2) model_frame();
      if (second_edge && k == 3) exp_ovr = 1'b1;
      eb = en && (k <= N + 1);
      ed = en && (k == N + 2);
      tests++;
      if (busy !== eb) begin
        fails++;
        $display("FAIL %s busy k=%0d got %b exp %b", tag, k, busy, eb);
      end
      tests++;
      if (update_done !== ed) begin
        fails++;
        $display("FAIL %s update_done k=%0d got %b exp %b",
                 tag, k, update_done, ed);
      end
      tests++;
      if (disc_x !== pack(0) || disc_y !== pack(1)) begin
        fails++;
        $display("FAIL %s pos k=%0d got x=%h y=%h exp x=%h y=%h",
                 tag, k, disc_x, disc_y, pack(0), pack(1));
      end
      tests++;
      if (overrun !== exp_ovr) begin
        fails++;
        $display("FAIL %s overrun k=%0d got %b exp %b",
                 tag, k, overrun, exp_ovr);
      end
      if (k == 1) begin
        vsync = 1'b1;
        if (drop) enable = 1'b0;
      end
      if (k == 2 && second_edge) vsync = 1'b0;
      if (k == 3) vsync = 1'b1;
    end
  endtask

  task automatic test_reset;
    do_reset();
    repeat (20) begin
      tick();
      tests++;
      if (disc_x !== pack(0) || disc_y !== pack(1)) begin
        fails++;
        $display("FAIL reset_pos got x=%h y=%h exp x=%h y=%h",
                 disc_x, disc_y, pack(0), pack(1));
      end
      tests++;
      if ({busy, update_done, overrun} !== 3'b000) begin
        fails++;
        $display("FAIL reset_flags got %b exp 000",
                 {busy, update_done, overrun});
      end
    end
  endtask

  task automatic test_first_frame;
    do_reset();
    do_frame(1'b1, 1'b0, 1'b0, "first");
    tests++;
    if (disc_x[CW-1:0] !== 10'd103 || disc_y[CW-1:0] !== 10'd98) begin
      fails++;
      $display("FAIL first_disc0 got (%0d,%0d) exp (103,98)",
               disc_x[CW-1:0], disc_y[CW-1:0]);
    end
  endtask

  task automatic test_bounce;
    do_reset();
    do_frame(1'b1, 1'b0, 1'b0, "bounce1");
    tests++;
    if (disc_x[2*CW-1:CW] !== 10'd607 || disc_y[2*CW-1:CW] !== 10'd447) begin
      fails++;
      $display("FAIL bounce_hit got (%0d,%0d) exp (607,447)",
               disc_x[2*CW-1:CW], disc_y[2*CW-1:CW]);
    end
    do_frame(1'b1, 1'b0, 1'b0, "bounce2");
    tests++;
    if (disc_x[2*CW-1:CW] !== 10'd603 || disc_y[2*CW-1:CW] !== 10'd444) begin
      fails++;
      $display("FAIL bounce_back got (%0d,%0d) exp (603,444)",
               disc_x[2*CW-1:CW], disc_y[2*CW-1:CW]);
    end
  endtask

  task automatic test_overrun;
    do_reset();
    do_frame(1'b1, 1'b0, 1'b1, "ovr_edge");
    do_frame(1'b1, 1'b0, 1'b0, "ovr_hold1");
    do_frame(1'b1, 1'b0, 1'b0, "ovr_hold2");
    do_reset();
    tick();
    tests++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL ovr_clear got %b exp 0", overrun);
    end
  endtask

  task automatic test_enable;
    do_reset();
    repeat (3) do_frame(1'b0, 1'b0, 1'b0, "en_off");
    do_frame(1'b1, 1'b0, 1'b0, "en_on");
    tests++;
    if (disc_x[CW-1:0] !== 10'd103 || disc_y[CW-1:0] !== 10'd98) begin
      fails++;
      $display("FAIL en_on_disc0 got (%0d,%0d) exp (103,98)",
               disc_x[CW-1:0], disc_y[CW-1:0]);
    end
  endtask

  task automatic test_mid_reset;
    do_reset();
    do_frame(1'b1, 1'b0, 1'b0, "pre_rst");
    enable = 1'b1;
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    exp_ovr = 1'b0;
    tests++;
    if (disc_x !== pack(0) || disc_y !== pack(1)) begin
      fails++;
      $display("FAIL midrst_pos got x=%h y=%h exp x=%h y=%h",
               disc_x, disc_y, pack(0), pack(1));
    end
    repeat (8) begin
      tests++;
      if ({busy, update_done, overrun} !== 3'b000) begin
        fails++;
        $display("FAIL midrst_flags got %b exp 000",
                 {busy, update_done, overrun});
      end
      tick();
    end
    do_frame(1'b1, 1'b0, 1'b0, "post_rst");
    tests++;
    if (disc_x[CW-1:0] !== 10'd103 || disc_y[CW-1:0] !== 10'd98) begin
      fails++;
      $display("FAIL post_rst_disc0 got (%0d,%0d) exp (103,98)",
               disc_x[CW-1:0], disc_y[CW-1:0]);
    end
  endtask

  task automatic test_random;
    logic en, drop;
    do_reset();
    repeat (300) begin
      repeat ($urandom_range(0, 3)) tick();
      en   = ($urandom_range(0, 3) != 0);
      drop = ($urandom_range(0, 5) == 0);
      do_frame(en, drop, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_bounce();
    test_overrun();
    test_enable();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
